// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q3.13 arctan table, angle format and the vectoring FSM states.
package cordic_pkg;

    localparam int ANGLE_FRAC = 13;
    localparam int ANGLE_W    = ANGLE_FRAC + 3;
    localparam int Z_W        = 18;
    localparam int MAX_ITER   = 16;

    localparam logic signed [Z_W-1:0] HALF_PI = 18'sd12868;

    // atan(2^-i) in Q3.13 radians; the last two entries round to zero.
    localparam logic signed [ANGLE_W-1:0] ATAN_TABLE [0:MAX_ITER-1] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
        16'sd511,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd0,    16'sd0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } cordic_state_e;

    function automatic logic signed [ANGLE_W-1:0] atan_q13(input logic [3:0] idx);
        return ATAN_TABLE[idx];
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation; the caller supplies the shift and arctan entry.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int XY_W = 19
) (
    input  logic signed [XY_W-1:0]    x_in,
    input  logic signed [XY_W-1:0]    y_in,
    input  logic signed [Z_W-1:0]     z_in,
    input  logic [3:0]                shift,
    input  logic signed [ANGLE_W-1:0] atan,
    output logic signed [XY_W-1:0]    x_out,
    output logic signed [XY_W-1:0]    y_out,
    output logic signed [Z_W-1:0]     z_out
);

    logic signed [XY_W-1:0] x_sh_s;
    logic signed [XY_W-1:0] y_sh_s;
    logic signed [Z_W-1:0]  atan_ext_s;

    // Rotate toward the positive x axis; both updates read the pre-update x and y.
    always_comb begin
        x_sh_s     = x_in >>> shift;
        y_sh_s     = y_in >>> shift;
        atan_ext_s = {{(Z_W-ANGLE_W){atan[ANGLE_W-1]}}, atan};
        if (!y_in[XY_W-1]) begin
            x_out = x_in + y_sh_s;
            y_out = y_in - x_sh_s;
            z_out = z_in + atan_ext_s;
        end else begin
            x_out = x_in - y_sh_s;
            y_out = y_in + x_sh_s;
            z_out = z_in - atan_ext_s;
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring unit: one vector in flight, a single micro-rotation stage reused
// once per cycle, result held until the consumer accepts it.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16,
    parameter int DATA_W     = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                In_valid,
    output logic                In_ready,
    input  logic [DATA_W-1:0]   X_in,
    input  logic [DATA_W-1:0]   Y_in,
    output logic                Out_valid,
    input  logic                Out_ready,
    output logic [DATA_W+1:0]   Magnitude,
    output logic [ANGLE_W-1:0]  Angle
);

    localparam int XY_W  = DATA_W + 3;
    localparam int MAG_W = DATA_W + 2;
    localparam logic [3:0] LAST_CNT = 4'(ITERATIONS - 1);

    cordic_state_e state_r;
    cordic_state_e state_nxt_s;

    logic signed [XY_W-1:0] x_r;
    logic signed [XY_W-1:0] y_r;
    logic signed [Z_W-1:0]  z_r;
    logic [3:0]             iter_cnt_r;
    logic                   zero_r;

    logic                   out_valid_r;
    logic [MAG_W-1:0]       magnitude_r;
    logic [ANGLE_W-1:0]     angle_r;

    logic                   in_ready_s;
    logic                   capture_s;
    logic                   iter_step_s;
    logic                   last_iter_s;
    logic                   out_xfer_s;

    logic signed [XY_W-1:0] x_ext_s;
    logic signed [XY_W-1:0] y_ext_s;
    logic signed [XY_W-1:0] x_pre_s;
    logic signed [XY_W-1:0] y_pre_s;
    logic signed [Z_W-1:0]  z_pre_s;
    logic                   zero_in_s;

    logic signed [XY_W-1:0] x_nxt_s;
    logic signed [XY_W-1:0] y_nxt_s;
    logic signed [Z_W-1:0]  z_nxt_s;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (In_valid) begin
                    state_nxt_s = ST_ITER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (iter_cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_DONE: begin
                if (Out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State decode: handshake and datapath enables.
    always_comb begin
        in_ready_s  = 1'b0;
        iter_step_s = 1'b0;
        last_iter_s = 1'b0;
        out_xfer_s  = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_ITER: begin
                iter_step_s = 1'b1;
                last_iter_s = (iter_cnt_r == LAST_CNT);
            end
            ST_DONE: out_xfer_s = Out_ready;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign capture_s = in_ready_s & In_valid;

    // Fold left-half-plane inputs by +/-90 degrees so the iterations only need to cover +/-99.9 degrees.
    always_comb begin
        x_ext_s   = {{(XY_W-DATA_W){X_in[DATA_W-1]}}, X_in};
        y_ext_s   = {{(XY_W-DATA_W){Y_in[DATA_W-1]}}, Y_in};
        zero_in_s = (X_in == {DATA_W{1'b0}}) && (Y_in == {DATA_W{1'b0}});
        if (!x_ext_s[XY_W-1]) begin
            x_pre_s = x_ext_s;
            y_pre_s = y_ext_s;
            z_pre_s = {Z_W{1'b0}};
        end else if (!y_ext_s[XY_W-1]) begin
            x_pre_s = y_ext_s;
            y_pre_s = -x_ext_s;
            z_pre_s = HALF_PI;
        end else begin
            x_pre_s = -y_ext_s;
            y_pre_s = x_ext_s;
            z_pre_s = -HALF_PI;
        end
    end

    cordic_vec_stage #(
        .XY_W (XY_W)
    ) u_stage (
        .x_in  (x_r),
        .y_in  (y_r),
        .z_in  (z_r),
        .shift (iter_cnt_r),
        .atan  (atan_q13(iter_cnt_r)),
        .x_out (x_nxt_s),
        .y_out (y_nxt_s),
        .z_out (z_nxt_s)
    );

    // Working registers: load on capture, advance one micro-rotation per ITER cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_r        <= {XY_W{1'b0}};
            y_r        <= {XY_W{1'b0}};
            z_r        <= {Z_W{1'b0}};
            iter_cnt_r <= 4'd0;
            zero_r     <= 1'b0;
        end else if (capture_s) begin
            x_r        <= x_pre_s;
            y_r        <= y_pre_s;
            z_r        <= z_pre_s;
            iter_cnt_r <= 4'd0;
            zero_r     <= zero_in_s;
        end else if (iter_step_s) begin
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            z_r        <= z_nxt_s;
            iter_cnt_r <= iter_cnt_r + 4'd1;
            zero_r     <= zero_r;
        end else begin
            x_r        <= x_r;
            y_r        <= y_r;
            z_r        <= z_r;
            iter_cnt_r <= iter_cnt_r;
            zero_r     <= zero_r;
        end
    end

    // Result registers: written by the last micro-rotation, held until the output transfer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_r <= 1'b0;
            magnitude_r <= {MAG_W{1'b0}};
            angle_r     <= {ANGLE_W{1'b0}};
        end else if (last_iter_s) begin
            out_valid_r <= 1'b1;
            magnitude_r <= zero_r ? {MAG_W{1'b0}} : x_nxt_s[MAG_W-1:0];
            angle_r     <= zero_r ? {ANGLE_W{1'b0}} : z_nxt_s[ANGLE_W-1:0];
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
            magnitude_r <= magnitude_r;
            angle_r     <= angle_r;
        end else begin
            out_valid_r <= out_valid_r;
            magnitude_r <= magnitude_r;
            angle_r     <= angle_r;
        end
    end

    assign In_ready  = in_ready_s;
    assign Out_valid = out_valid_r;
    assign Magnitude = magnitude_r;
    assign Angle     = angle_r;

endmodule
